// File: rtl/decode_packet_unit.sv
// Decode stage after the packet-FIFO read controller: verifies the header checksum,
// then streams the payload as flits to the lane named in the header.
module decode_packet_unit #(
    parameter int FLIT_W = 16,
    parameter int PKT_W  = 72,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  pkt_data,
    input  logic              start_decode_pkt,
    output logic              ready_decode_pkt,
    output logic              decode_done,
    output logic              pkt_err,
    output logic [3:0]        lane_valid,
    output logic [FLIT_W-1:0] lane_data,
    input  logic [3:0]        lane_ready,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        dbg_state
);

    localparam int HDR_LSB = 4 * FLIT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PKT_W-1:0] pkt_q;
    logic [1:0]       flit_idx_q;
    logic             err_flag_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [1:0]        hdr_lane;
    logic [1:0]        hdr_len_m1;
    logic [3:0]        hdr_csum;
    logic [3:0]        csum_calc;
    logic [FLIT_W-1:0] flit_sel;

    assign hdr_lane   = pkt_q[HDR_LSB+6 +: 2];
    assign hdr_len_m1 = pkt_q[HDR_LSB+4 +: 2];
    assign hdr_csum   = pkt_q[HDR_LSB +: 4];

    // The payload holds 4*FLIT_W bits, i.e. FLIT_W nibbles.
    always_comb begin
        csum_calc = '0;
        for (int i = 0; i < FLIT_W; i++) begin
            csum_calc = csum_calc ^ pkt_q[4*i +: 4];
        end
    end

    always_comb begin
        flit_sel = '0;
        case (flit_idx_q)
            2'd0: flit_sel = pkt_q[0*FLIT_W +: FLIT_W];
            2'd1: flit_sel = pkt_q[1*FLIT_W +: FLIT_W];
            2'd2: flit_sel = pkt_q[2*FLIT_W +: FLIT_W];
            2'd3: flit_sel = pkt_q[3*FLIT_W +: FLIT_W];
            default: flit_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pkt_q      <= '0;
            flit_idx_q <= '0;
            err_flag_q <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_decode_pkt) begin
                        pkt_q      <= pkt_data;
                        flit_idx_q <= '0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (csum_calc == hdr_csum) begin
                        state_q <= S_SEND;
                    end else begin
                        err_flag_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_SEND: begin
                    // Only the selected lane's ready matters.
                    if (lane_ready[hdr_lane]) begin
                        if (flit_idx_q == hdr_len_m1) begin
                            state_q <= S_DONE;
                        end else begin
                            flit_idx_q <= flit_idx_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (err_flag_q) begin
                        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
                    end else begin
                        if (pkt_cnt_q != {CNT_W{1'b1}}) pkt_cnt_q <= pkt_cnt_q + 1'b1;
                    end
                    err_flag_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_decode_pkt = (state_q == S_IDLE);
    assign decode_done      = (state_q == S_DONE);
    assign pkt_err          = (state_q == S_DONE) && err_flag_q;
    assign lane_valid       = (state_q == S_SEND) ? (4'b0001 << hdr_lane) : 4'b0000;
    assign lane_data        = (state_q == S_SEND) ? flit_sel : '0;
    assign pkt_cnt          = pkt_cnt_q;
    assign err_cnt          = err_cnt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_decode_packet_unit.sv
// Directed bench for decode_packet_unit: table of packets plus hand-written
// sequences for reset mid-packet and counter saturation.
module tb_decode_packet_unit;

    localparam int FLIT_W = 16;
    localparam int PKT_W  = 72;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic              clk;
    logic              rst;
    logic [PKT_W-1:0]  pkt_data;
    logic              start_decode_pkt;
    logic              ready_decode_pkt;
    logic              decode_done;
    logic              pkt_err;
    logic [3:0]        lane_valid;
    logic [FLIT_W-1:0] lane_data;
    logic [3:0]        lane_ready;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [1:0]        dbg_state;

    int n_checks;
    int n_fail;

    decode_packet_unit #(.FLIT_W(FLIT_W), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_data         (pkt_data),
        .start_decode_pkt (start_decode_pkt),
        .ready_decode_pkt (ready_decode_pkt),
        .decode_done      (decode_done),
        .pkt_err          (pkt_err),
        .lane_valid       (lane_valid),
        .lane_data        (lane_data),
        .lane_ready       (lane_ready),
        .pkt_cnt          (pkt_cnt),
        .err_cnt          (err_cnt),
        .dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       lane;
        logic [1:0]       len_m1;
        logic [63:0]      payload;
        logic             bad;
        int               stall0;
        logic [CNT_W-1:0] exp_pkt;
        logic [CNT_W-1:0] exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [1:0] lane, input logic [1:0] len_m1,
                                                 input logic [63:0] payload, input logic bad);
        logic [3:0] cs;
        cs = 4'h0;
        for (int i = 0; i < 16; i++) cs = cs ^ payload[4*i +: 4];
        if (bad) cs[0] = ~cs[0];
        return {lane, len_m1, cs, payload};
    endfunction

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_pkt(input logic [PKT_W-1:0] pkt, input logic bad, input int stall0,
                           input logic [CNT_W-1:0] exp_pkt, input logic [CNT_W-1:0] exp_err);
        logic [3:0] onehot;
        int         len;
        onehot = 4'b0001 << pkt[71:70];
        len    = int'(pkt[69:68]) + 1;
        chk("idle_ready", 64'(ready_decode_pkt), 64'd1);
        chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));
        pkt_data         = pkt;
        start_decode_pkt = 1'b1;
        lane_ready       = 4'hF;
        @(negedge clk);
        start_decode_pkt = 1'b0;
        pkt_data         = '0;
        chk("check_state", 64'(dbg_state), 64'(ST_CHECK));
        chk("check_valid", 64'(lane_valid), 64'd0);
        chk("check_not_ready", 64'(ready_decode_pkt), 64'd0);
        @(negedge clk);
        if (!bad) begin
            for (int k = 0; k < len; k++) begin
                for (int s = 0; s <= ((k == 0) ? stall0 : 0); s++) begin
                    chk("send_state", 64'(dbg_state), 64'(ST_SEND));
                    chk("send_valid", 64'(lane_valid), 64'(onehot));
                    chk("send_data", 64'(lane_data), 64'(pkt[16*k +: 16]));
                    chk("send_no_done", 64'(decode_done), 64'd0);
                    lane_ready = (k == 0 && s < stall0) ? ~onehot : 4'hF;
                    @(negedge clk);
                end
            end
        end
        chk("done_pulse", 64'(decode_done), 64'd1);
        chk("done_err", 64'(pkt_err), 64'(bad));
        chk("done_valid", 64'(lane_valid), 64'd0);
        chk("done_data", 64'(lane_data), 64'd0);
        lane_ready = 4'hF;
        @(negedge clk);
        chk("after_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("after_done", 64'(decode_done), 64'd0);
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        logic [PKT_W-1:0] p;
        logic [CNT_W-1:0] exp_pc;
        logic [CNT_W-1:0] exp_ec;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{2'd2, 2'd3, 64'h0004_0003_0002_0001, 1'b0, 0, 4'd1, 4'd0};
        vecs[1] = '{2'd2, 2'd3, 64'h0004_0003_0002_0001, 1'b1, 0, 4'd1, 4'd1};
        vecs[2] = '{2'd0, 2'd1, 64'h0000_0000_BEEF_1234, 1'b0, 3, 4'd2, 4'd1};
        vecs[3] = '{2'd1, 2'd2, 64'h0000_5555_AAAA_0F0F, 1'b0, 2, 4'd3, 4'd1};
        vecs[4] = '{2'd3, 2'd0, 64'hFFFF_FFFF_FFFF_C0DE, 1'b0, 0, 4'd4, 4'd1};

        rst              = 1'b1;
        pkt_data         = '0;
        start_decode_pkt = 1'b0;
        lane_ready       = 4'hF;
        #1;
        chk("rst_ready", 64'(ready_decode_pkt), 64'd1);
        chk("rst_valid", 64'(lane_valid), 64'd0);
        chk("rst_done", 64'(decode_done), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_pkt(mk_pkt(vecs[v].lane, vecs[v].len_m1, vecs[v].payload, vecs[v].bad),
                    vecs[v].bad, vecs[v].stall0, vecs[v].exp_pkt, vecs[v].exp_err);
        end

        // Reset while the second of four flits is on offer.
        p = mk_pkt(2'd2, 2'd3, 64'h1111_2222_3333_4444, 1'b0);
        pkt_data         = p;
        start_decode_pkt = 1'b1;
        @(negedge clk);
        start_decode_pkt = 1'b0;
        @(negedge clk);
        chk("mid_flit0", 64'(lane_data), 64'h4444);
        @(negedge clk);
        chk("mid_flit1", 64'(lane_data), 64'h3333);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("mid_rst_valid", 64'(lane_valid), 64'd0);
        chk("mid_rst_data", 64'(lane_data), 64'd0);
        chk("mid_rst_ready", 64'(ready_decode_pkt), 64'd1);
        chk("mid_rst_done", 64'(decode_done), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_done", 64'(decode_done), 64'd0);
        run_pkt(mk_pkt(2'd1, 2'd3, 64'h0A0A_0B0B_0C0C_0D0D, 1'b0), 1'b0, 0, 4'd1, 4'd0);

        // Back-to-back good packets with start held high: pkt_cnt saturates.
        exp_pc           = 4'd1;
        pkt_data         = mk_pkt(2'd3, 2'd0, 64'h0000_0000_0000_00A5, 1'b0);
        start_decode_pkt = 1'b1;
        for (int n = 0; n < 16; n++) begin
            chk("b2b_idle", 64'(dbg_state), 64'(ST_IDLE));
            chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'(exp_pc));
            @(negedge clk);
            chk("b2b_check", 64'(dbg_state), 64'(ST_CHECK));
            @(negedge clk);
            chk("b2b_send", 64'(lane_valid), 64'h8);
            @(negedge clk);
            chk("b2b_done", 64'(decode_done), 64'd1);
            if (n == 15) start_decode_pkt = 1'b0;
            if (exp_pc != 4'hF) exp_pc = exp_pc + 4'd1;
            @(negedge clk);
        end
        chk("sat_pkt_cnt", 64'(pkt_cnt), 64'hF);
        chk("sat_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Back-to-back bad packets: err_cnt saturates, pkt_cnt untouched.
        exp_ec           = 4'd0;
        pkt_data         = mk_pkt(2'd0, 2'd1, 64'h0000_0000_1234_5678, 1'b1);
        start_decode_pkt = 1'b1;
        for (int n = 0; n < 17; n++) begin
            chk("bad_idle", 64'(dbg_state), 64'(ST_IDLE));
            chk("bad_err_cnt", 64'(err_cnt), 64'(exp_ec));
            @(negedge clk);
            @(negedge clk);
            chk("bad_done", 64'(decode_done), 64'd1);
            chk("bad_err", 64'(pkt_err), 64'd1);
            chk("bad_valid", 64'(lane_valid), 64'd0);
            if (n == 16) start_decode_pkt = 1'b0;
            if (exp_ec != 4'hF) exp_ec = exp_ec + 4'd1;
            @(negedge clk);
        end
        chk("sat_err_cnt", 64'(err_cnt), 64'hF);
        chk("sat_pkt_kept", 64'(pkt_cnt), 64'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
